// File: rtl/fifo_access_arb.sv
// Write/read access arbiter in front of a synchronous FIFO: two round-robin producers and one
// consumer. Writes and reads strictly alternate while both are pending.
module fifo_access_arb #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0,
    input  logic                          req1,
    input  logic [DATA_WIDTH-1:0]         din0,
    input  logic [DATA_WIDTH-1:0]         din1,
    output logic                          gnt0,
    output logic                          gnt1,
    input  logic                          rd_req,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic                          fifo_wen,
    output logic                          fifo_ren,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ctrl_full,
    output logic                          ctrl_empty
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MaxCount = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] One      = CW'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} op_e;

    op_e           state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q;

    logic can_wr, can_rd, wr_pend, rd_pend, do_wr, do_rd, sel1;

    always_comb begin
        can_wr  = (count_q < MaxCount);
        can_rd  = (count_q != '0);
        wr_pend = (req0 | req1) & can_wr;
        rd_pend = rd_req & can_rd;
        // Write wins a tie unless the previous op was itself a write.
        do_wr   = wr_pend & ~(rd_pend & (state_q == StWrite));
        do_rd   = rd_pend & ~do_wr;
        sel1    = (req0 & req1) ? rr_q : req1;

        gnt0     = 1'b0;
        gnt1     = 1'b0;
        fifo_wen = 1'b0;
        fifo_ren = 1'b0;
        rd_gnt   = 1'b0;
        fifo_din = '0;
        rr_d     = rr_q;
        count_d  = count_q;
        state_d  = StIdle;

        if (do_wr) begin
            fifo_wen = 1'b1;
            fifo_din = sel1 ? din1 : din0;
            gnt0     = ~sel1;
            gnt1     = sel1;
            rr_d     = ~sel1;
            count_d  = count_q + One;
            state_d  = StWrite;
        end else if (do_rd) begin
            fifo_ren = 1'b1;
            rd_gnt   = 1'b1;
            count_d  = count_q - One;
            state_d  = StRead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_gnt;
        end
    end

    assign count      = count_q;
    assign rd_valid   = rd_valid_q;
    assign ctrl_full  = ~can_wr;
    assign ctrl_empty = ~can_rd;

endmodule

// File: tb/tb_fifo_access_arb.sv
// Self-checking bench for fifo_access_arb: directed scenarios then random traffic against a
// queue-based reference model, with a behavioural FIFO attached to the enables.
module tb_fifo_access_arb;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, rd_req;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1, rd_gnt, rd_valid, fifo_wen, fifo_ren, ctrl_full, ctrl_empty;
    logic [DW-1:0] fifo_din;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fifo_access_arb #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .din0       (din0),
        .din1       (din1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .fifo_wen   (fifo_wen),
        .fifo_ren   (fifo_ren),
        .fifo_din   (fifo_din),
        .count      (count),
        .ctrl_full  (ctrl_full),
        .ctrl_empty (ctrl_empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: occupancy, last op (0 none, 1 write, 2 read), round-robin pointer.
    int            m_occ;
    int            m_last;
    bit            m_rr;
    bit            m_rdv;
    logic [DW-1:0] m_exp_rd;
    logic [DW-1:0] acc_q[$];
    // Behavioural FIFO driven by the DUT's enables.
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] fifo_dout;

    task automatic model_reset();
        m_occ  = 0;
        m_last = 0;
        m_rr   = 1'b0;
        m_rdv  = 1'b0;
        acc_q.delete();
        fifo_mem.delete();
        fifo_dout = '0;
    endtask

    task automatic cycle(input bit r0, input bit r1, input bit rd,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit            want_w, want_r, ew, er, sel;
        logic [DW-1:0] ed, nd;
        req0 = r0; req1 = r1; rd_req = rd; din0 = d0; din1 = d1;
        #1;
        want_w = (r0 || r1) && (m_occ < int'(DEPTH) - 1);
        want_r = rd && (m_occ > 0);
        ew     = want_w && !(want_r && m_last == 1);
        er     = want_r && !ew;
        sel    = (r0 && r1) ? m_rr : r1;
        ed     = ew ? (sel ? d1 : d0) : '0;

        check("count", 32'(count), 32'(m_occ));
        check("ctrl_full", 32'(ctrl_full), 32'(m_occ >= int'(DEPTH) - 1));
        check("ctrl_empty", 32'(ctrl_empty), 32'(m_occ == 0));
        check("gnt0", 32'(gnt0), 32'(ew && !sel));
        check("gnt1", 32'(gnt1), 32'(ew && sel));
        check("fifo_wen", 32'(fifo_wen), 32'(ew));
        check("fifo_din", 32'(fifo_din), 32'(ed));
        check("fifo_ren", 32'(fifo_ren), 32'(er));
        check("rd_gnt", 32'(rd_gnt), 32'(er));
        check("rd_valid", 32'(rd_valid), 32'(m_rdv));
        check("wen_ren_excl", 32'(fifo_wen & fifo_ren), 32'(0));
        if (m_rdv) check("rd_data", 32'(fifo_dout), 32'(m_exp_rd));

        nd = fifo_dout;
        if (fifo_ren) begin
            if (fifo_mem.size() > 0) nd = fifo_mem.pop_front();
        end else if (fifo_wen) begin
            fifo_mem.push_back(fifo_din);
        end

        if (ew) begin
            acc_q.push_back(ed);
            m_occ++;
            m_rr   = !sel;
            m_last = 1;
        end else if (er) begin
            m_exp_rd = acc_q.pop_front();
            m_occ--;
            m_last = 2;
        end else begin
            m_last = 0;
        end
        m_rdv = er;

        @(posedge clk);
        fifo_dout = nd;
        #1;
    endtask

    initial begin
        int wp, rp;
        rst_n = 1'b0; req0 = 0; req1 = 0; rd_req = 0; din0 = '0; din1 = '0;
        model_reset();
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_empty", 32'(ctrl_empty), 32'(1));
        check("rst_full", 32'(ctrl_full), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write then read of 0xA5.
        cycle(1, 0, 0, 8'hA5, 8'h00);
        check("s1_count", 32'(count), 32'(1));
        cycle(0, 0, 1, 8'h00, 8'h00);
        check("s1_rd_valid", 32'(rd_valid), 32'(1));
        check("s1_dout", 32'(fifo_dout), 32'hA5);
        check("s1_count0", 32'(count), 32'(0));

        // Both producers until full; grants alternate via the model.
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 8'h10, 8'h20);
        check("full_count", 32'(count), 32'(DEPTH - 1));
        check("full_flag", 32'(ctrl_full), 32'(1));
        cycle(1, 0, 0, 8'h33, 8'h00);
        // Drain, then read at empty.
        for (int i = 0; i < 17; i++) cycle(0, 0, 1, 8'h00, 8'h00);
        check("empty_count", 32'(count), 32'(0));

        // count=5, idle, then req1+rd_req held: write/read alternation.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(i), 8'h00);
        cycle(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 8'h00, 8'(8'h40 + i));
        check("alt_count", 32'(count), 32'(5));

        // Bring to count=7 with a read in flight, then async reset mid-cycle.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'h70 + i), 8'h00);
        cycle(0, 0, 1, 8'h00, 8'h00);
        check("pre_rst_count", 32'(count), 32'(7));
        check("pre_rst_rdv", 32'(rd_valid), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'(0));
        check("arst_rd_valid", 32'(rd_valid), 32'(0));
        check("arst_empty", 32'(ctrl_empty), 32'(1));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(0, 1, 0, 8'h00, 8'h5A);
        check("post_rst_count", 32'(count), 32'(1));

        // Random traffic with phase-varying bias to reach both full and empty.
        for (int ph = 0; ph < 20; ph++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 500; i++)
                cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < wp),
                      ($urandom_range(0, 99) < rp), 8'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
